// File: rtl/Falco_pkg.sv
// Falco shared types and sizing for the rename free list.
// Imported by the rename-stage blocks.
package Falco_pkg;

  localparam int PRF_NUM  = 64;
  localparam int PRF_W    = $clog2(PRF_NUM);
  localparam int FL_DEPTH = PRF_NUM - 32;
  localparam int FL_IDX_W = $clog2(FL_DEPTH);
  localparam int FL_PTR_W = FL_IDX_W + 1;
  localparam int FL_BASE  = 32;

  typedef logic [PRF_W-1:0]    prf_specifier_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [FL_IDX_W-1:0] fl_idx_t;

  localparam fl_ptr_t FL_DEPTH_PTR = fl_ptr_t'(FL_DEPTH);

endpackage

// File: rtl/free_list.sv
// Dual-pop / dual-push circular free list of physical registers.
// Speculative read pointer is rewound to the commit pointer on flush.
module free_list
  import Falco_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                pop0_req,
  input  logic                pop1_req,
  output prf_specifier_t      pop_prf0,
  output prf_specifier_t      pop_prf1,
  output logic                pop_ok,
  input  logic                push0_valid,
  input  logic                push1_valid,
  input  prf_specifier_t      push0_prf,
  input  prf_specifier_t      push1_prf,
  input  logic                commit0_alloc,
  input  logic                commit1_alloc,
  input  logic                flush,
  output logic [FL_PTR_W-1:0] free_count
);

  prf_specifier_t r_mem [FL_DEPTH];
  fl_ptr_t        r_rd_ptr;
  fl_ptr_t        r_wr_ptr;
  fl_ptr_t        r_cmt_ptr;

  logic [1:0]     w_need;
  logic [1:0]     w_push_n;
  logic [1:0]     w_cmt_n;
  fl_ptr_t        w_rd_p1;
  fl_ptr_t        w_wr_p1;
  fl_ptr_t        w_rd_next;
  fl_ptr_t        w_wr_next;
  fl_ptr_t        w_cmt_next;
  fl_idx_t        w_rd_idx0;
  fl_idx_t        w_rd_idx1;
  fl_idx_t        w_wr_idx0;
  fl_idx_t        w_wr_idx1;

  function automatic fl_ptr_t ptr_add(input fl_ptr_t p, input logic [1:0] n);
    return p + fl_ptr_t'(n);
  endfunction

  // Occupancy, grant and combinational read ports
  always_comb begin
    w_need     = {1'b0, pop0_req} + {1'b0, pop1_req};
    w_push_n   = {1'b0, push0_valid} + {1'b0, push1_valid};
    w_cmt_n    = {1'b0, commit0_alloc} + {1'b0, commit1_alloc};
    free_count = r_wr_ptr - r_rd_ptr;
    pop_ok     = (free_count >= fl_ptr_t'(w_need)) && !flush;
    w_rd_p1    = ptr_add(r_rd_ptr, 2'd1);
    w_wr_p1    = ptr_add(r_wr_ptr, 2'd1);
    w_rd_idx0  = r_rd_ptr[FL_IDX_W-1:0];
    w_rd_idx1  = pop0_req ? w_rd_p1[FL_IDX_W-1:0] : w_rd_idx0;
    w_wr_idx0  = r_wr_ptr[FL_IDX_W-1:0];
    w_wr_idx1  = push0_valid ? w_wr_p1[FL_IDX_W-1:0] : w_wr_idx0;
    pop_prf0   = r_mem[w_rd_idx0];
    pop_prf1   = r_mem[w_rd_idx1];
  end

  // Next pointer values; flush rewinds to the post-commit position
  always_comb begin
    w_cmt_next = ptr_add(r_cmt_ptr, w_cmt_n);
    w_wr_next  = ptr_add(r_wr_ptr, w_push_n);
    w_rd_next  = r_rd_ptr;
    if (flush)
      w_rd_next = w_cmt_next;
    else if (pop_ok)
      w_rd_next = ptr_add(r_rd_ptr, w_need);
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_cmt_ptr <= '0;
      r_wr_ptr  <= FL_DEPTH_PTR;
    end else begin
      r_rd_ptr  <= w_rd_next;
      r_cmt_ptr <= w_cmt_next;
      r_wr_ptr  <= w_wr_next;
    end
  end

  // Entry storage; pushes are compacted into consecutive slots
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        r_mem[i] <= prf_specifier_t'(FL_BASE + i);
    end else begin
      if (push0_valid)
        r_mem[w_wr_idx0] <= push0_prf;
      if (push1_valid)
        r_mem[w_wr_idx1] <= push1_prf;
    end
  end

  // Overflow and commit-overtakes-rename sanity checks
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (fl_ptr_t'(w_wr_next - w_cmt_next) <= FL_DEPTH_PTR)
        else $error("free_list overflow: wr-cmt beyond depth");
      assert (fl_ptr_t'(w_rd_next - w_cmt_next) <= FL_DEPTH_PTR)
        else $error("free_list commit pointer passed read pointer");
    end
  end

endmodule
